// File: rtl/regfile_sb_if.sv
// Bundle of read, write, reservation and flush signals between the issue and write-back stages and the register file.
// Ports: rs1/rs2 -> rdata1/rdata2 and busy1/busy2; we/wa/wdata/wrel write-back; iss_valid/iss_rd -> iss_stall; flush.
// master drives the requests (pipeline side); slave is the register file.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            busy1;
    logic            busy2;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wdata;
    logic            wrel;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_stall;
    logic            flush;

    modport master (
        output rs1, rs2, we, wa, wdata, wrel, iss_valid, iss_rd, flush,
        input  rdata1, rdata2, busy1, busy2, iss_stall
    );

    modport slave (
        input  rs1, rs2, we, wa, wdata, wrel, iss_valid, iss_rd, flush,
        output rdata1, rdata2, busy1, busy2, iss_stall
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file (2R/1W) with a per-register pending-write counter for RAW/WAW hazard detection.
// Latency: reads, busy and iss_stall are combinational; writes and counter changes land on the clk edge.
// Backpressure: iss_stall refuses a reservation when the destination counter is saturated.
// Ports: clk, reset (async, active-high), bus (regfile_sb_if.slave) carrying read, write, issue and flush signals.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int CNTW     = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int NREG = 1 << AW;
    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [XLEN-1:0] regs [NREG];
    logic [CNTW-1:0] cnt  [NREG];

    logic            z1, z2, zw, zi;
    logic            rel1, rel2;
    logic            stall;
    logic [NREG-1:0] inc_v, dec_v;

    assign z1 = ZERO_REG && (bus.rs1 == '0);
    assign z2 = ZERO_REG && (bus.rs2 == '0);
    assign zw = ZERO_REG && (bus.wa == '0);
    assign zi = ZERO_REG && (bus.iss_rd == '0);

    // Read ports: hardwired zero wins over bypass, bypass wins over the array.
    always_comb begin
        if (z1)
            bus.rdata1 = '0;
        else if (BYPASS && bus.we && (bus.wa == bus.rs1))
            bus.rdata1 = bus.wdata;
        else
            bus.rdata1 = regs[bus.rs1];
    end

    always_comb begin
        if (z2)
            bus.rdata2 = '0;
        else if (BYPASS && bus.we && (bus.wa == bus.rs2))
            bus.rdata2 = bus.wdata;
        else
            bus.rdata2 = regs[bus.rs2];
    end

    // The last outstanding write arriving this cycle satisfies the source,
    // since its data is already on the read port through the bypass.
    assign rel1 = BYPASS && bus.we && bus.wrel && (bus.wa == bus.rs1) && (cnt[bus.rs1] == CNT_ONE);
    assign rel2 = BYPASS && bus.we && bus.wrel && (bus.wa == bus.rs2) && (cnt[bus.rs2] == CNT_ONE);

    assign bus.busy1 = !z1 && (cnt[bus.rs1] != '0) && !rel1;
    assign bus.busy2 = !z2 && (cnt[bus.rs2] != '0) && !rel2;

    // Deliberately ignores a same-cycle release so the stall path stays short.
    assign stall         = bus.iss_valid && (cnt[bus.iss_rd] == CNT_MAX) && !zi;
    assign bus.iss_stall = stall;

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 0; r < NREG; r++) begin
            inc_v[r] = bus.iss_valid && !stall && (bus.iss_rd == AW'(r)) && !(ZERO_REG && (r == 0));
            // No decrement from zero: a stray release only writes data.
            dec_v[r] = bus.we && bus.wrel && (bus.wa == AW'(r)) && (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else if (bus.flush) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc_v[r] && !dec_v[r])
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (dec_v[r] && !inc_v[r])
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end

    // Flush does not suppress the data write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else if (bus.we && !zw) begin
            regs[bus.wa] <= bus.wdata;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected output values, a monitor compares them.
// Latency: inputs change 2 time units after posedge, outputs are sampled on the following negedge.
// Backpressure: none; iss_stall is checked as an ordinary output.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam int P_RD1   = 0;
    localparam int P_RD2   = 1;
    localparam int P_BUSY1 = 2;
    localparam int P_BUSY2 = 3;
    localparam int P_STALL = 4;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_sb #(
        .XLEN(XLEN), .AW(AW), .CNTW(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic expect_val(input string n, input int p, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.port = p;
        e.val  = v;
        sbq.push_back(e);
    endtask

    // Advance to just after the next rising edge and return control inputs to idle.
    task automatic cyc();
        @(posedge clk);
        #2;
        bus.we        = 1'b0;
        bus.wrel      = 1'b0;
        bus.iss_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    // Monitor: outputs are combinational, so every pending expectation is
    // compared at the negedge following its stimulus.
    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                case (e.port)
                    P_RD1:   act = bus.rdata1;
                    P_RD2:   act = bus.rdata2;
                    P_BUSY1: act = {31'b0, bus.busy1};
                    P_BUSY2: act = {31'b0, bus.busy2};
                    default: act = {31'b0, bus.iss_stall};
                endcase
                tests++;
                if (act !== e.val) begin
                    fails++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin : stimulus
        reset         = 1'b1;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.we        = 1'b0;
        bus.wa        = '0;
        bus.wdata     = '0;
        bus.wrel      = 1'b0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // Reset state of every register on both ports.
        for (int i = 0; i < 32; i++) begin
            cyc();
            bus.rs1 = AW'(i);
            bus.rs2 = AW'(31 - i);
            expect_val($sformatf("rst_rd1_r%0d", i), P_RD1, 32'h0);
            expect_val($sformatf("rst_rd2_r%0d", 31 - i), P_RD2, 32'h0);
            expect_val($sformatf("rst_busy1_r%0d", i), P_BUSY1, 32'h0);
            expect_val($sformatf("rst_busy2_r%0d", 31 - i), P_BUSY2, 32'h0);
        end
        expect_val("rst_stall", P_STALL, 32'h0);

        // Write reg5, then assert reset between edges.
        cyc();
        bus.we = 1'b1; bus.wa = 5'd5; bus.wdata = 32'hDEADBEEF; bus.rs1 = 5'd5;
        expect_val("wr5_bypass", P_RD1, 32'hDEADBEEF);
        cyc();
        bus.rs1 = 5'd5;
        expect_val("wr5_stored", P_RD1, 32'hDEADBEEF);
        cyc();
        reset = 1'b1;
        expect_val("async_rst_rd5", P_RD1, 32'h0);
        cyc();
        reset = 1'b0;

        // Bypass on reg3, hardwired zero on reg0.
        cyc();
        bus.we = 1'b1; bus.wa = 5'd3; bus.wdata = 32'h12345678; bus.rs1 = 5'd3;
        expect_val("wr3_bypass", P_RD1, 32'h12345678);
        cyc();
        bus.rs1 = 5'd3; bus.rs2 = 5'd3;
        expect_val("wr3_stored_p1", P_RD1, 32'h12345678);
        expect_val("wr3_stored_p2", P_RD2, 32'h12345678);
        cyc();
        bus.we = 1'b1; bus.wa = 5'd0; bus.wdata = 32'hFFFFFFFF; bus.rs1 = 5'd0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        expect_val("wr0_no_bypass", P_RD1, 32'h0);
        expect_val("iss0_no_stall", P_STALL, 32'h0);
        cyc();
        bus.rs1 = 5'd0;
        expect_val("wr0_stored", P_RD1, 32'h0);
        expect_val("r0_not_busy", P_BUSY1, 32'h0);

        // Three reservations on reg7, a refused fourth, then three releases.
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs1 = 5'd7;
            expect_val($sformatf("iss7_busy_k%0d", k), P_BUSY1, (k == 0) ? 32'h0 : 32'h1);
            expect_val($sformatf("iss7_stall_k%0d", k), P_STALL, 32'h0);
        end
        cyc();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs1 = 5'd7;
        expect_val("iss7_saturated_stall", P_STALL, 32'h1);
        expect_val("iss7_saturated_busy", P_BUSY1, 32'h1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.we = 1'b1; bus.wrel = 1'b1; bus.wa = 5'd7;
            bus.wdata = 32'h70 + 32'(k); bus.rs1 = 5'd7;
            expect_val($sformatf("rel7_busy_k%0d", k), P_BUSY1, (k == 2) ? 32'h0 : 32'h1);
        end
        cyc();
        bus.rs1 = 5'd7; bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        expect_val("rel7_done_busy", P_BUSY1, 32'h0);
        expect_val("rel7_done_data", P_RD1, 32'h72);
        expect_val("rel7_done_stall", P_STALL, 32'h0);
        cyc();
        bus.we = 1'b1; bus.wrel = 1'b1; bus.wa = 5'd7; bus.wdata = 32'h73;

        // Simultaneous issue and release on reg9 with one outstanding write.
        cyc();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; bus.rs1 = 5'd9;
        expect_val("iss9_busy_before", P_BUSY1, 32'h0);
        cyc();
        bus.rs1 = 5'd9;
        expect_val("iss9_busy_after", P_BUSY1, 32'h1);
        cyc();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        bus.we = 1'b1; bus.wrel = 1'b1; bus.wa = 5'd9; bus.wdata = 32'h99; bus.rs1 = 5'd9;
        expect_val("iss_rel9_busy_now", P_BUSY1, 32'h0);
        expect_val("iss_rel9_data_now", P_RD1, 32'h99);
        expect_val("iss_rel9_stall", P_STALL, 32'h0);
        cyc();
        bus.rs1 = 5'd9;
        expect_val("iss_rel9_busy_next", P_BUSY1, 32'h1);
        expect_val("iss_rel9_data_next", P_RD1, 32'h99);
        cyc();
        bus.we = 1'b1; bus.wrel = 1'b1; bus.wa = 5'd9; bus.wdata = 32'h9A;

        // Release with no reservation on reg4.
        cyc();
        bus.we = 1'b1; bus.wrel = 1'b1; bus.wa = 5'd4; bus.wdata = 32'hA5A5A5A5; bus.rs1 = 5'd4;
        expect_val("rel4_busy_now", P_BUSY1, 32'h0);
        cyc();
        bus.rs1 = 5'd4; bus.rs2 = 5'd9;
        expect_val("rel4_data", P_RD1, 32'hA5A5A5A5);
        expect_val("rel4_no_underflow", P_BUSY1, 32'h0);
        expect_val("rel9_clean", P_BUSY2, 32'h0);

        // Reserve 1..3, then flush together with an issue to 10 and a write to reg2.
        for (int k = 1; k <= 3; k++) begin
            cyc();
            bus.iss_valid = 1'b1; bus.iss_rd = AW'(k);
        end
        cyc();
        bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 5'd10;
        bus.we = 1'b1; bus.wa = 5'd2; bus.wdata = 32'h55;
        bus.rs1 = 5'd1; bus.rs2 = 5'd3;
        expect_val("pre_flush_busy1", P_BUSY1, 32'h1);
        expect_val("pre_flush_busy3", P_BUSY2, 32'h1);
        expect_val("flush_iss_stall", P_STALL, 32'h0);
        cyc();
        bus.rs1 = 5'd1; bus.rs2 = 5'd2;
        expect_val("flush_busy1", P_BUSY1, 32'h0);
        expect_val("flush_busy2", P_BUSY2, 32'h0);
        expect_val("flush_wr2_data", P_RD2, 32'h55);
        cyc();
        bus.rs1 = 5'd3; bus.rs2 = 5'd10;
        expect_val("flush_busy3", P_BUSY1, 32'h0);
        expect_val("flush_r10_unreserved", P_BUSY2, 32'h0);

        cyc();
        @(negedge clk);
        #1;
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a built-in per-register pending-write scoreboard for the pipelined core. It provides two combinational read ports with same-cycle write-back bypass and one write port, with an optionally hardwired zero register. It also tracks outstanding in-flight writes per destination register so the issue stage can detect RAW/WAW hazards and stall. It sits between the decode/issue stage (reads, reservations) and the write-back stage (writes, releases).

## Interface
- XLEN, 32, data width in bits
- AW, 5, register address width; NREG = 2**AW registers
- CNTW, 2, pending-counter width per register; max outstanding writes per register = 2**CNTW-1
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes/reservations; 0: register 0 is ordinary
- BYPASS, 1, 1: same-cycle write data forwarded to read ports; 0: reads show stored value only

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears registers and counters
- rs1, rs2  in  AW  read addresses
- rdata1, rdata2  out  XLEN  read data (combinational)
- busy1, busy2  out  1  source register has pending write not satisfied this cycle
- we  in  1  write enable
- wa  in  AW  write address
- wdata  in  XLEN  write data
- wrel  in  1  with we: this write retires one reservation on wa
- iss_valid  in  1  reserve destination iss_rd
- iss_rd  in  AW  destination to reserve
- iss_stall  out  1  counter of iss_rd saturated; reservation refused
- flush  in  1  synchronously clears all pending counters

## Operation
- Storage: NREG x XLEN array plus NREG x CNTW counters cnt[].
- Write: on clk edge, if we and not (ZERO_REG and wa==0), reg[wa] <= wdata. A write without wrel updates data and leaves cnt unchanged.
- Read i: if ZERO_REG and rs_i==0, rdata_i = 0. Otherwise, if BYPASS and we and wa==rs_i, rdata_i = wdata. Otherwise rdata_i = reg[rs_i].
- busy_i = (cnt[rs_i] != 0), forced 0 when:
  - ZERO_REG and rs_i==0;
  - BYPASS and we and wrel and wa==rs_i and cnt[rs_i]==1 (last outstanding write arriving now).
- iss_stall = iss_valid and cnt[iss_rd] == 2**CNTW-1 and not (ZERO_REG and iss_rd==0). It does not account for a same-cycle release.
- Counter update per register r, evaluated at the edge:
  - inc = iss_valid and !iss_stall and iss_rd==r and not (ZERO_REG and r==0)
  - dec = we and wrel and wa==r and cnt[r]!=0
  - inc and dec both set: cnt unchanged. inc only: +1. dec only: -1.
  - Release with cnt==0: no underflow, cnt stays 0; the data write still happens.
- flush: all cnt <= 0. It takes priority over any inc/dec in the same cycle. The register write in that cycle still occurs.
- No simulation print statements in RTL.

## Timing
- Reads, busy and iss_stall are combinational from inputs and current state; zero latency.
- A write is visible through the array the cycle after the edge, and in the same cycle via bypass when BYPASS=1.
- A reservation made at edge N makes busy assert from cycle N+1.
- Reset (asynchronous, any time, including mid-burst): all reg=0 and all cnt=0 immediately. Outputs then are rdata=0 (absent bypass), busy=0, and iss_stall=0. No edge is required.
- Deassertion of reset takes effect on the next clk edge; inputs sampled at that edge act normally.

## Test plan
- Reset then read all registers: rdata1/rdata2=0 and busy=0 for rs 0..31. Assert reset mid-operation after writing reg5=0xDEADBEEF: rdata for rs1=5 drops to 0 without a clock edge.
- Write reg3=0x12345678 with rs1=3 in the same cycle and BYPASS=1: rdata1=0x12345678 that cycle, and it persists afterwards. Write reg0=0xFFFFFFFF with ZERO_REG=1: rdata reads 0.
- Issue iss_rd=7 for three cycles (CNTW=2): busy on rs=7 asserts. A fourth issue gives iss_stall=1 and cnt stays 3. Three wrel writes then bring busy to 0 on the third write cycle (forced by the cnt==1 rule).
- Simultaneous issue and release on reg9 with cnt=1: cnt stays 1, busy stays 1 the next cycle, and rdata shows the new wdata.
- Release on reg4 with cnt=0 and wdata=0xA5A5A5A5: cnt stays 0 and reg4=0xA5A5A5A5.
- Reserve regs 1, 2 and 3, then flush together with an issue to reg 10 and a write to reg2=0x55: all busy=0 the next cycle, reg10 is not reserved, and reg2=0x55.
